directory_controller: RTL

DIRECTORY_CONTROLLER -- requirements
Module: directory_controller

---
 rtl/directory_controller_if.sv | 45 ++++
 rtl/directory_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/directory_controller_if.sv
// Request, coherence-command, memory and reply bundle for directory_controller.
// master = caches/memory side, slave = directory.
interface directory_controller_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqProc;
  logic [2:0]        ReqType;
  logic [ADDR_W-1:0] ReqAddress;
  logic [DATA_W-1:0] ReqData;
  logic              CmdValid;
  logic              CmdProc;
  logic [2:0]        CmdType;
  logic [ADDR_W-1:0] CmdAddress;
  logic              CmdAck;
  logic [DATA_W-1:0] AckData;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;
  logic              RespValid;
  logic              RespProc;
  logic [ADDR_W-1:0] RespAddress;
  logic [DATA_W-1:0] RespData;
  logic              Busy;

  modport master (
    output ReqValid, ReqProc, ReqType, ReqAddress, ReqData,
    output CmdAck, AckData, MemRData,
    input  ReqReady, CmdValid, CmdProc, CmdType, CmdAddress,
    input  MemRead, MemWrite, MemAddress, MemWData,
    input  RespValid, RespProc, RespAddress, RespData, Busy
  );

  modport slave (
    input  ReqValid, ReqProc, ReqType, ReqAddress, ReqData,
    input  CmdAck, AckData, MemRData,
    output ReqReady, CmdValid, CmdProc, CmdType, CmdAddress,
    output MemRead, MemWrite, MemAddress, MemWData,
    output RespValid, RespProc, RespAddress, RespData, Busy
  );
endinterface

// File: rtl/directory_controller.sv
// Two-cache MSI-style directory controller, one entry per block address.
// DIR_STATS_EN adds saturating ReadMiss/WriteMiss/Invalidate counters.
module directory_controller #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input logic Clock,
  input logic Reset,
  directory_controller_if.slave bus
`ifdef DIR_STATS_EN
  ,
  output logic [7:0] ReadMissCount,
  output logic [7:0] WriteMissCount,
  output logic [7:0] InvCount
`endif
);
  localparam int ENTRIES = 2**ADDR_W;
  localparam logic [2:0] RD_MISS = 3'b001;
  localparam logic [2:0] WR_MISS = 3'b010;
  localparam logic [2:0] WR_BACK = 3'b011;
  localparam logic [2:0] CMD_FETCH = 3'b011;
  localparam logic [2:0] CMD_FINV = 3'b100;
  localparam logic [2:0] CMD_INV = 3'b101;
  localparam logic [1:0] UNCACHED = 2'b00;
  localparam logic [1:0] SHARED = 2'b01;
  localparam logic [1:0] EXCL = 2'b10;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, SEND_CMD, WAIT_ACK,
    MEM_RD, MEM_WR, REPLY
  } fsmState_t;

  fsmState_t state, nextState;

  logic [1:0] dirState [ENTRIES];
  logic [1:0] dirSharers [ENTRIES];

  logic              reqProc;
  logic [2:0]        reqType;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] holdData;
  logic [2:0]        cmdType, nextCmdType;
  logic              fromMem;

  logic [1:0] curState, curSharers;
  logic [1:0] reqBit, otherBit;
  logic       otherHolds, selfHolds, ownedByOther;
  logic       isRead, isWrite, isWb;
  logic       rdFetch, rdMem, wrFinv, wrInv, wrMem, wbOwner;
  logic       accept;

  assign curState = dirState[reqAddr];
  assign curSharers = dirSharers[reqAddr];
  assign reqBit = reqProc ? 2'b10 : 2'b01;
  assign otherBit = reqProc ? 2'b01 : 2'b10;
  assign otherHolds = |(curSharers & otherBit);
  assign selfHolds = |(curSharers & reqBit);
  assign ownedByOther = (curState == EXCL) && otherHolds;
  assign isRead = (reqType == RD_MISS);
  assign isWrite = (reqType == WR_MISS);
  assign isWb = (reqType == WR_BACK);
  assign rdFetch = isRead && ownedByOther;
  assign rdMem = isRead && !ownedByOther;
  assign wrFinv = isWrite && ownedByOther;
  assign wrInv = isWrite && (curState == SHARED) && otherHolds;
  assign wrMem = isWrite && !wrFinv && !wrInv;
  assign wbOwner = isWb && (curState == EXCL) && selfHolds;
  assign accept = bus.ReqValid && (state == IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    nextCmdType = cmdType;
    bus.ReqReady = 1'b0;
    bus.CmdValid = 1'b0;
    bus.CmdProc = 1'b0;
    bus.CmdType = 3'b000;
    bus.CmdAddress = '0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemAddress = '0;
    bus.MemWData = '0;
    bus.RespValid = 1'b0;
    bus.RespProc = 1'b0;
    bus.RespAddress = '0;
    bus.RespData = '0;
    bus.Busy = (state != IDLE);
    case (state)
      IDLE: begin
        bus.ReqReady = 1'b1;
        if (bus.ReqValid) nextState = LOOKUP;
      end
      LOOKUP: begin
        unique case (1'b1)
          rdFetch: begin
            nextCmdType = CMD_FETCH;
            nextState = SEND_CMD;
          end
          wrFinv: begin
            nextCmdType = CMD_FINV;
            nextState = SEND_CMD;
          end
          wrInv: begin
            nextCmdType = CMD_INV;
            nextState = SEND_CMD;
          end
          rdMem, wrMem: nextState = MEM_RD;
          wbOwner: nextState = MEM_WR;
          default: nextState = IDLE;
        endcase
      end
      SEND_CMD, WAIT_ACK: begin
        // Command held steady until the owner acknowledges it
        bus.CmdValid = 1'b1;
        bus.CmdProc = ~reqProc;
        bus.CmdType = cmdType;
        bus.CmdAddress = reqAddr;
        if (state == SEND_CMD) nextState = WAIT_ACK;
        else if (bus.CmdAck)
          nextState = (cmdType == CMD_INV) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.MemAddress = reqAddr;
        nextState = REPLY;
      end
      MEM_WR: begin
        bus.MemWrite = 1'b1;
        bus.MemAddress = reqAddr;
        bus.MemWData = holdData;
        nextState = isWb ? IDLE : REPLY;
      end
      REPLY: begin
        bus.RespValid = 1'b1;
        bus.RespProc = reqProc;
        bus.RespAddress = reqAddr;
        bus.RespData = fromMem ? bus.MemRData : holdData;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      reqProc <= 1'b0;
      reqType <= 3'b000;
      reqAddr <= '0;
      holdData <= '0;
      cmdType <= 3'b000;
      fromMem <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        dirState[i] <= UNCACHED;
        dirSharers[i] <= 2'b00;
      end
    end else begin
      cmdType <= nextCmdType;
      if (accept) begin
        reqProc <= bus.ReqProc;
        reqType <= bus.ReqType;
        reqAddr <= bus.ReqAddress;
        holdData <= bus.ReqData;
      end
      if (state == WAIT_ACK && bus.CmdAck) holdData <= bus.AckData;
      if (state == MEM_RD) fromMem <= 1'b1;
      else if (state == MEM_WR) fromMem <= 1'b0;
      if (state == MEM_WR && isWb) begin
        dirState[reqAddr] <= UNCACHED;
        dirSharers[reqAddr] <= 2'b00;
      end
      if (state == REPLY) begin
        if (isRead) begin
          dirState[reqAddr] <= SHARED;
          dirSharers[reqAddr] <= curSharers | reqBit;
        end else begin
          dirState[reqAddr] <= EXCL;
          dirSharers[reqAddr] <= reqBit;
        end
      end
    end
  end

`ifdef DIR_STATS_EN
  logic issueInv;
  assign issueInv = (state == LOOKUP) && (wrFinv || wrInv);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ReadMissCount <= 8'd0;
      WriteMissCount <= 8'd0;
      InvCount <= 8'd0;
    end else begin
      if (accept && bus.ReqType == RD_MISS && ReadMissCount != 8'hFF)
        ReadMissCount <= ReadMissCount + 8'd1;
      if (accept && bus.ReqType == WR_MISS && WriteMissCount != 8'hFF)
        WriteMissCount <= WriteMissCount + 8'd1;
      if (issueInv && InvCount != 8'hFF)
        InvCount <= InvCount + 8'd1;
    end
  end
`endif
endmodule
